// File: rtl/csw_ram_arbiter_if.sv
// Memory-side bus of the CSW RAM arbiter: one outstanding byte access,
// request held as a level until the one-cycle acknowledge.
interface csw_ram_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/csw_ram_arbiter.sv
// Shares one RAM port between the download writer, the CPU and the CSW tape
// player: fixed priority with a CPU burst limit, one access in flight, timeout.
module csw_ram_arbiter #(
    parameter int ADDR_W    = 25,
    parameter int CPU_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,

    input  logic              tape_rd,
    input  logic [ADDR_W-1:0] tape_a,
    output logic              tape_iocycle,
    output logic [7:0]        tape_d,

    input  logic              err_clr,
    output logic              timeout_err,

    csw_ram_arbiter_if.master mem
);

    localparam int BW = $clog2(CPU_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TREL} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_CPU, OWN_TAPE} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    owner_t            win_d;
    logic [BW-1:0]     burst_q;
    logic [7:0]        tmo_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              dl_ack_q;
    logic              cpu_ack_q;
    logic [7:0]        cpu_rdata_q;
    logic              tape_io_q;
    logic [7:0]        tape_d_q;
    logic              err_q;

    logic              tape_pri;
    logic              done;
    logic [7:0]        rdat;

    // Tape jumps ahead of the CPU once the CPU has used up its burst allowance.
    assign tape_pri = tape_rd && (!cpu_req || (burst_q >= BW'(CPU_BURST)));

    always_comb begin
        win_d = OWN_NONE;
        if (dl_req)        win_d = OWN_DL;
        else if (tape_pri) win_d = OWN_TAPE;
        else if (cpu_req)  win_d = OWN_CPU;
        else if (tape_rd)  win_d = OWN_TAPE;
    end

    // An expired access completes exactly like an acked one, with 8'hFF data.
    assign done = mem.mem_ack || (tmo_q == 8'(TIMEOUT - 1));
    assign rdat = mem.mem_ack ? mem.mem_rdata : 8'hFF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            burst_q     <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dl_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            tape_io_q   <= 1'b0;
            tape_d_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            dl_ack_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            if (err_clr) err_q <= 1'b0;
            if (!tape_rd) burst_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (win_d != OWN_NONE) begin
                        owner_q   <= win_d;
                        mem_req_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_WAIT;
                    end
                    case (win_d)
                        OWN_DL: begin
                            mem_addr_q  <= dl_addr;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= dl_data;
                        end
                        OWN_CPU: begin
                            mem_addr_q  <= cpu_addr;
                            mem_we_q    <= cpu_we;
                            mem_wdata_q <= cpu_wdata;
                            if (tape_rd && (burst_q < BW'(CPU_BURST)))
                                burst_q <= burst_q + 1'b1;
                        end
                        OWN_TAPE: begin
                            mem_addr_q <= tape_a;
                            mem_we_q   <= 1'b0;
                            tape_io_q  <= 1'b1;
                            burst_q    <= '0;
                        end
                        default: ;
                    endcase
                end

                S_WAIT: begin
                    if (done) begin
                        mem_req_q <= 1'b0;
                        if (!mem.mem_ack) err_q <= 1'b1;
                        case (owner_q)
                            OWN_DL: begin
                                dl_ack_q <= 1'b1;
                                state_q  <= S_RESP;
                            end
                            OWN_CPU: begin
                                cpu_ack_q <= 1'b1;
                                if (!mem_we_q) cpu_rdata_q <= rdat;
                                state_q   <= S_RESP;
                            end
                            OWN_TAPE: begin
                                tape_d_q <= rdat;
                                state_q  <= S_TREL;
                            end
                            default: state_q <= S_RESP;
                        endcase
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end

                // Strobe falls a cycle after tape_d lands; the following RESP
                // cycle gives the player its two cycles to advance tape_a.
                S_TREL: begin
                    tape_io_q <= 1'b0;
                    state_q   <= S_RESP;
                end

                S_RESP: begin
                    owner_q <= OWN_NONE;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign dl_ack       = dl_ack_q;
    assign cpu_ack      = cpu_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign tape_iocycle = tape_io_q;
    assign tape_d       = tape_d_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_csw_ram_arbiter.sv
// Scoreboard bench for csw_ram_arbiter: expected grants and responses are
// queued by the stimulus and popped by a negedge monitor.
module tb_csw_ram_arbiter;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dl_req, dl_ack;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          tape_rd, tape_iocycle;
    logic [AW-1:0] tape_a;
    logic [7:0]    tape_d;
    logic          err_clr, timeout_err;

    always #5 clk = ~clk;

    csw_ram_arbiter_if #(.ADDR_W(AW)) mem_if();

    csw_ram_arbiter #(.ADDR_W(AW), .CPU_BURST(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .tape_rd(tape_rd), .tape_a(tape_a), .tape_iocycle(tape_iocycle), .tape_d(tape_d),
        .err_clr(err_clr), .timeout_err(timeout_err),
        .mem(mem_if)
    );

    typedef struct { logic [AW-1:0] addr; logic we; logic [7:0] wdata; } grant_t;
    typedef struct { int kind; logic chkd; logic [7:0] data; } resp_t;

    grant_t gq[$];
    resp_t  rq[$];
    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic exp_grant(input logic [AW-1:0] a, input logic we, input logic [7:0] wd);
        grant_t g;
        g.addr = a; g.we = we; g.wdata = wd;
        gq.push_back(g);
    endtask

    // kind: 1 = dl_ack, 2 = cpu_ack, 3 = tape strobe fall
    task automatic exp_resp(input int kind, input logic chkd, input logic [7:0] d);
        resp_t r;
        r.kind = kind; r.chkd = chkd; r.data = d;
        rq.push_back(r);
    endtask

    // Memory model: acks after 'lat' extra cycles of mem_req; reads return
    // stored bytes or addr[7:0]^8'h3C for untouched locations.
    logic [7:0] mem_arr [int];
    int lat = 0;
    bit noack = 0;
    bit stray = 0;
    int mcnt = 0;

    function automatic logic [7:0] mrd(input logic [AW-1:0] a);
        if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
        return a[7:0] ^ 8'h3C;
    endfunction

    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 8'h00;
        mem_arr[int'(25'h200020)] = 8'h44;
        forever begin
            @(posedge clk); #1;
            mem_if.mem_ack = 1'b0;
            if (stray) begin
                mem_if.mem_ack = 1'b1;
                mem_if.mem_rdata = 8'h99;
                stray = 0;
            end else if (reset_n && mem_if.mem_req && !noack) begin
                if (mcnt >= lat) begin
                    mem_if.mem_ack = 1'b1;
                    mem_if.mem_rdata = mrd(mem_if.mem_addr);
                    if (mem_if.mem_we) mem_arr[int'(mem_if.mem_addr)] = mem_if.mem_wdata;
                    mcnt = 0;
                end else mcnt++;
            end else mcnt = 0;
        end
    end

    // Monitor
    logic req_p = 0, io_p = 0;
    logic [7:0] td_p = 0;
    int req_len = 0, last_req_len = 0, io_len = 0, last_io_len = 0;
    grant_t mg;
    resp_t  mr;

    task automatic pop_resp(input int kind, input logic [7:0] d);
        if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_resp: got kind %0d data 0x%0h expected none", kind, d);
        end else begin
            mr = rq.pop_front();
            chk("resp_kind", kind, mr.kind);
            if (mr.chkd) chk("resp_data", d, mr.data);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            req_p = 0; io_p = 0; req_len = 0; io_len = 0;
        end else begin
            if (mem_if.mem_req && !req_p) begin
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_grant: got addr 0x%0h expected none", mem_if.mem_addr);
                end else begin
                    mg = gq.pop_front();
                    chk("grant_addr", mem_if.mem_addr, mg.addr);
                    chk("grant_we", mem_if.mem_we, mg.we);
                    if (mg.we) chk("grant_wdata", mem_if.mem_wdata, mg.wdata);
                end
            end
            if (mem_if.mem_req) req_len = req_p ? req_len + 1 : 1;
            else if (req_p) last_req_len = req_len;
            if (tape_iocycle) io_len = io_p ? io_len + 1 : 1;
            else if (io_p) last_io_len = io_len;
            if (dl_ack) pop_resp(1, 8'h00);
            if (cpu_ack) pop_resp(2, cpu_rdata);
            if (io_p && !tape_iocycle) begin
                pop_resp(3, tape_d);
                chk("tape_d_stable", td_p, tape_d);
            end
            req_p = mem_if.mem_req;
            io_p = tape_iocycle;
            td_p = tape_d;
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0: return mem_if.mem_req;
            1: return dl_ack;
            2: return cpu_ack;
            3: return !tape_iocycle;
            4: return tape_iocycle;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int w, input int budget, input string nm);
        int n = 0;
        @(negedge clk); #1;
        while (!sig(w) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, sig(w), 1);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_ctl"}, {mem_if.mem_req, mem_if.mem_we, dl_ack, cpu_ack, tape_iocycle, timeout_err}, 0);
        chk({nm, "_addr"}, mem_if.mem_addr, 0);
        chk({nm, "_data"}, {mem_if.mem_wdata, cpu_rdata, tape_d}, 0);
    endtask

    initial begin
        dl_req = 0; dl_addr = '0; dl_data = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        tape_rd = 0; tape_a = '0; err_clr = 0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset_n = 1;

        // reset in the middle of a WAIT
        noack = 1;
        exp_grant(25'h50, 0, 8'h00);
        cpu_addr = 25'h50; cpu_req = 1;
        wait_ev(0, 10, "rst_grant");
        repeat (3) @(negedge clk);
        #2 reset_n = 0;
        #1 chk_quiet("midwait_reset");
        cpu_req = 0; noack = 0;
        @(negedge clk); reset_n = 1;

        // single tape read, memory acks in the second request cycle
        lat = 1;
        exp_grant(25'h200020, 0, 8'h00);
        exp_resp(3, 1, 8'h44);
        tape_a = 25'h200020; tape_rd = 1;
        wait_ev(4, 10, "tape_rise");
        wait_ev(3, 10, "tape_fall");
        tape_rd = 0;
        chk("tape_io_len", last_io_len, 3);
        lat = 0;

        // CPU write then readback
        exp_grant(25'h100, 1, 8'hA5);
        exp_resp(2, 0, 8'h00);
        cpu_we = 1; cpu_addr = 25'h100; cpu_wdata = 8'hA5; cpu_req = 1;
        wait_ev(2, 20, "wr_ack");
        cpu_req = 0; cpu_we = 0;
        chk("wr_req_len", last_req_len, 1);
        @(negedge clk); #1;
        chk("wr_ack_pulse", cpu_ack, 0);
        exp_grant(25'h100, 0, 8'h00);
        exp_resp(2, 1, 8'hA5);
        cpu_req = 1;
        wait_ev(2, 20, "rd_ack");
        cpu_req = 0;

        // priority: all three at once -> dl, cpu, tape
        exp_grant(25'h300, 1, 8'h5C);
        exp_grant(25'h40, 0, 8'h00);
        exp_grant(25'h200020, 0, 8'h00);
        exp_resp(1, 0, 8'h00);
        exp_resp(2, 1, 8'h7C);
        exp_resp(3, 1, 8'h44);
        dl_addr = 25'h300; dl_data = 8'h5C; cpu_addr = 25'h40;
        dl_req = 1; cpu_req = 1; tape_rd = 1;
        begin
            logic iop = 0;
            for (int n = 0; n < 60 && (dl_req || cpu_req || tape_rd); n++) begin
                @(negedge clk); #1;
                if (dl_ack) dl_req = 0;
                if (cpu_ack) cpu_req = 0;
                if (iop && !tape_iocycle) tape_rd = 0;
                iop = tape_iocycle;
            end
        end
        chk("prio_done", {dl_req, cpu_req, tape_rd}, 0);

        // starvation guard: 4 CPU, 1 tape, then CPU again with a fresh burst count
        for (int i = 0; i < 4; i++) begin exp_grant(25'h40, 0, 8'h00); exp_resp(2, 1, 8'h7C); end
        exp_grant(25'h200020, 0, 8'h00); exp_resp(3, 1, 8'h44);
        for (int i = 0; i < 2; i++) begin exp_grant(25'h40, 0, 8'h00); exp_resp(2, 1, 8'h7C); end
        cpu_req = 1; tape_rd = 1;
        begin
            logic iop = 0;
            int ca = 0, tf = 0;
            for (int n = 0; n < 200 && cpu_req; n++) begin
                @(negedge clk); #1;
                if (cpu_ack) ca++;
                if (iop && !tape_iocycle) tf++;
                iop = tape_iocycle;
                if (ca == 6 && tf == 1) begin cpu_req = 0; tape_rd = 0; end
            end
            chk("starve_cpu_acks", ca, 6);
            chk("starve_tape", tf, 1);
        end
        cpu_req = 0; tape_rd = 0;

        // timeout on a CPU read
        noack = 1;
        exp_grant(25'h50, 0, 8'h00);
        exp_resp(2, 1, 8'hFF);
        cpu_addr = 25'h50; cpu_req = 1;
        wait_ev(2, 400, "tmo_ack");
        cpu_req = 0; noack = 0;
        chk("tmo_req_len", last_req_len, 255);
        chk("tmo_err_set", timeout_err, 1);

        // late ack in IDLE must be ignored
        stray = 1;
        repeat (3) @(negedge clk); #1;
        chk("stray_quiet", {mem_if.mem_req, cpu_ack, dl_ack}, 0);
        chk("stray_err_kept", timeout_err, 1);

        err_clr = 1;
        @(negedge clk); #1;
        err_clr = 0;
        chk("err_cleared", timeout_err, 0);

        // err_clr on the same edge as a fresh timeout: set wins
        noack = 1;
        exp_grant(25'h50, 0, 8'h00);
        exp_resp(2, 1, 8'hFF);
        cpu_req = 1;
        wait_ev(0, 10, "tmo2_grant");
        repeat (254) @(negedge clk);
        #1 err_clr = 1;
        @(negedge clk); #1;
        err_clr = 0; cpu_req = 0; noack = 0;
        chk("tmo2_ack_timing", cpu_ack, 1);
        chk("tmo2_err_set_wins", timeout_err, 1);

        // requester drops cpu_req mid-access
        lat = 3;
        exp_grant(25'h40, 0, 8'h00);
        exp_resp(2, 1, 8'h7C);
        cpu_addr = 25'h40; cpu_req = 1;
        wait_ev(0, 10, "drop_grant");
        repeat (2) @(negedge clk);
        #1 cpu_req = 0;
        chk("drop_req_held", mem_if.mem_req, 1);
        wait_ev(2, 10, "drop_ack");
        repeat (6) @(negedge clk); #1;
        chk("drop_no_regrant", mem_if.mem_req, 0);
        lat = 0;

        chk("grants_left", gq.size(), 0);
        chk("resps_left", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
